// File: rtl/branch_predictor.sv
// Bimodal branch predictor: untagged table of 2-bit counters with per-entry
// target, combinational fetch lookup, execute-stage training and mispredict stats.
module branch_predictor #(
    parameter int INDEX_BITS = 4,
    parameter int CNT_BITS   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pred_valid,
    input  logic [31:0]         pred_pc,
    output logic                pred_taken,
    output logic [31:0]         pred_target,
    input  logic                upd_valid,
    input  logic [31:0]         upd_pc,
    input  logic                upd_taken,
    input  logic [31:0]         upd_target,
    input  logic                upd_pred_taken,
    input  logic [31:0]         upd_pred_target,
    output logic                mispredict,
    output logic [CNT_BITS-1:0] mispredict_count
);

    localparam int DEPTH = 1 << INDEX_BITS;

    logic [1:0]            cnt_q    [DEPTH];
    logic [1:0]            cnt_d    [DEPTH];
    logic [31:0]           target_q [DEPTH];
    logic [31:0]           target_d [DEPTH];
    logic [DEPTH-1:0]      valid_q;
    logic [DEPTH-1:0]      valid_d;
    logic                  mispredict_q;
    logic                  mispredict_d;
    logic [CNT_BITS-1:0]   count_q;
    logic [CNT_BITS-1:0]   count_d;

    logic [INDEX_BITS-1:0] pred_idx;
    logic [INDEX_BITS-1:0] upd_idx;
    logic                  upd_miss;
    logic                  unused_pc_bits;

    assign pred_idx = pred_pc[INDEX_BITS+1:2];
    assign upd_idx  = upd_pc[INDEX_BITS+1:2];

    // Tables are untagged, so the upper PC bits only determine aliasing.
    assign unused_pc_bits = ^{pred_pc[31:INDEX_BITS+2], pred_pc[1:0],
                              upd_pc[31:INDEX_BITS+2], upd_pc[1:0]};

    // Lookup reads registered state only, so a same-cycle update is not bypassed.
    assign pred_taken  = pred_valid & valid_q[pred_idx] & cnt_q[pred_idx][1];
    assign pred_target = pred_taken ? target_q[pred_idx] : 32'h0;

    assign upd_miss = upd_valid &
                      ((upd_pred_taken != upd_taken) |
                       (upd_taken & upd_pred_taken & (upd_pred_target != upd_target)));

    always_comb begin
        cnt_d    = cnt_q;
        target_d = target_q;
        valid_d  = valid_q;
        if (upd_valid) begin
            if (upd_taken) begin
                if (cnt_q[upd_idx] != 2'b11) begin
                    cnt_d[upd_idx] = cnt_q[upd_idx] + 2'd1;
                end
                target_d[upd_idx] = upd_target;
                valid_d[upd_idx]  = 1'b1;
            end else if (cnt_q[upd_idx] != 2'b00) begin
                cnt_d[upd_idx] = cnt_q[upd_idx] - 2'd1;
            end
        end
    end

    always_comb begin
        mispredict_d = upd_miss;
        count_d      = count_q;
        if (upd_miss && (count_q != {CNT_BITS{1'b1}})) begin
            count_d = count_q + {{(CNT_BITS-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt_q[i]    <= 2'b01;
                target_q[i] <= 32'h0;
            end
            valid_q      <= '0;
            mispredict_q <= 1'b0;
            count_q      <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt_q[i]    <= cnt_d[i];
                target_q[i] <= target_d[i];
            end
            valid_q      <= valid_d;
            mispredict_q <= mispredict_d;
            count_q      <= count_d;
        end
    end

    assign mispredict       = mispredict_q;
    assign mispredict_count = count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: a driver queues expected responses per
// cycle and a negedge monitor pops and compares them against the DUT.
module tb_branch_predictor;

    localparam int INDEX_BITS = 4;
    localparam int CNT_BITS   = 4;

    logic                clk;
    logic                rst_n;
    logic                pred_valid;
    logic [31:0]         pred_pc;
    logic                pred_taken;
    logic [31:0]         pred_target;
    logic                upd_valid;
    logic [31:0]         upd_pc;
    logic                upd_taken;
    logic [31:0]         upd_target;
    logic                upd_pred_taken;
    logic [31:0]         upd_pred_target;
    logic                mispredict;
    logic [CNT_BITS-1:0] mispredict_count;

    branch_predictor #(
        .INDEX_BITS(INDEX_BITS),
        .CNT_BITS  (CNT_BITS)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pred_valid       (pred_valid),
        .pred_pc          (pred_pc),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_taken        (upd_taken),
        .upd_target       (upd_target),
        .upd_pred_taken   (upd_pred_taken),
        .upd_pred_target  (upd_pred_target),
        .mispredict       (mispredict),
        .mispredict_count (mispredict_count)
    );

    // Clock and cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: sel 0 pred_taken, 1 pred_target, 2 mispredict, 3 mispredict_count.
    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur;
    logic [31:0] got;
    int          checks = 0;
    int          errors = 0;

    task automatic expect_at(input int off, input int sel, input logic [31:0] val,
                             input string name);
        exp_t e;
        e.cyc  = cyc + off;
        e.sel  = sel;
        e.val  = val;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic chk_pred(input logic taken, input logic [31:0] tgt, input string name);
        expect_at(0, 0, {31'h0, taken}, {name, ".taken"});
        expect_at(0, 1, tgt, {name, ".target"});
    endtask

    task automatic chk_miss(input int off, input logic m, input int count, input string name);
        expect_at(off, 2, {31'h0, m}, {name, ".mispredict"});
        expect_at(off, 3, count, {name, ".count"});
    endtask

    // Monitor.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            cur = exp_q.pop_front();
            case (cur.sel)
                0:       got = {31'h0, pred_taken};
                1:       got = pred_target;
                2:       got = {31'h0, mispredict};
                default: got = {{(32-CNT_BITS){1'b0}}, mispredict_count};
            endcase
            checks++;
            if (cur.cyc != cyc || got !== cur.val) begin
                errors++;
                $display("FAIL %s cyc=%0d got=0x%0h expected=0x%0h (due cyc %0d)",
                         cur.name, cyc, got, cur.val, cur.cyc);
            end
        end
    end

    // Driver tasks.
    task automatic idle();
        pred_valid      = 1'b0;
        pred_pc         = 32'h0;
        upd_valid       = 1'b0;
        upd_pc          = 32'h0;
        upd_taken       = 1'b0;
        upd_target      = 32'h0;
        upd_pred_taken  = 1'b0;
        upd_pred_target = 32'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic pred(input logic [31:0] pc);
        pred_valid = 1'b1;
        pred_pc    = pc;
    endtask

    task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                       input logic ptaken, input logic [31:0] ptgt);
        upd_valid       = 1'b1;
        upd_pc          = pc;
        upd_taken       = taken;
        upd_target      = tgt;
        upd_pred_taken  = ptaken;
        upd_pred_target = ptgt;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state.
        pred(32'h40); chk_pred(1'b0, 32'h0, "reset"); chk_miss(0, 1'b0, 0, "reset");
        tick();

        // Train to taken: cnt 01 -> 10, first-time taken is a mispredict.
        pred(32'h40); upd(32'h40, 1'b1, 32'h80, 1'b0, 32'h0);
        chk_pred(1'b0, 32'h0, "train0"); chk_miss(1, 1'b1, 1, "train0");
        tick();
        for (int i = 0; i < 3; i++) begin
            pred(32'h40); upd(32'h40, 1'b1, 32'h80, 1'b1, 32'h80);
            chk_pred(1'b1, 32'h80, "train_ok"); chk_miss(1, 1'b0, 1, "train_ok");
            tick();
        end

        // Hysteresis: 11 -> 10 still taken, then a same-cycle update 10 -> 01.
        pred(32'h40); upd(32'h40, 1'b0, 32'h0, 1'b1, 32'h80);
        chk_pred(1'b1, 32'h80, "nt1"); chk_miss(1, 1'b1, 2, "nt1");
        tick();
        pred(32'h40); upd(32'h40, 1'b0, 32'h0, 1'b1, 32'h80);
        chk_pred(1'b1, 32'h80, "same_cycle"); chk_miss(1, 1'b1, 3, "nt2");
        tick();
        pred(32'h40);
        chk_pred(1'b0, 32'h0, "after_nt2"); chk_miss(1, 1'b0, 3, "idle_after_nt2");
        tick();

        // Target mismatch: cnt 01 -> 10, target becomes 0x90.
        pred(32'h40); upd(32'h40, 1'b1, 32'h90, 1'b1, 32'h80);
        chk_pred(1'b0, 32'h0, "tgt_mis_pre"); chk_miss(1, 1'b1, 4, "tgt_mis");
        tick();
        pred(32'h40);
        chk_pred(1'b1, 32'h90, "tgt_new"); chk_miss(1, 1'b0, 4, "idle_tgt");
        tick();

        // Aliasing: 0x80 shares index 0 with 0x40; 0x44 is index 1 and untrained.
        pred(32'h80); chk_pred(1'b1, 32'h90, "alias_80");
        tick();
        pred(32'h44); chk_pred(1'b0, 32'h0, "index1");
        tick();
        pred_pc = 32'h40; chk_pred(1'b0, 32'h0, "pred_valid_low");
        tick();

        // Correctly predicted not-taken does not count.
        pred(32'h44); upd(32'h44, 1'b0, 32'h0, 1'b0, 32'h0);
        chk_pred(1'b0, 32'h0, "nt_ok"); chk_miss(1, 1'b0, 4, "nt_ok");
        tick();

        // Back-to-back mispredicts, count saturates at 15.
        for (int i = 1; i <= 20; i++) begin
            upd(32'h48, 1'b1, 32'h200, 1'b0, 32'h0);
            chk_miss(1, 1'b1, (4 + i > 15) ? 15 : 4 + i, "sat");
            tick();
        end

        // Reset wins over a simultaneous update.
        rst_n = 1'b0;
        upd(32'h4C, 1'b1, 32'h100, 1'b0, 32'h0);
        tick();
        rst_n = 1'b1;
        pred(32'h4C);
        chk_pred(1'b0, 32'h0, "rst_drop"); chk_miss(0, 1'b0, 0, "rst_clear");
        tick();
        pred(32'h40); upd(32'h4C, 1'b1, 32'h100, 1'b0, 32'h0);
        chk_pred(1'b0, 32'h0, "rst_discard"); chk_miss(1, 1'b1, 1, "post_rst");
        tick();
        // One taken update from the reset value 01 must flip the prediction.
        pred(32'h4C); chk_pred(1'b1, 32'h100, "post_rst_cnt01");
        tick();

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            $display("FAIL drain pending=%0d required=0", exp_q.size());
            errors += exp_q.size();
            checks += exp_q.size();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
